// File: rtl/mcu_strip.sv
// Memory control unit for a K x K convolution strip engine: loads M = N+K-1 line banks,
// feeds N convolver windows, writes results back in place, then drains them to the host.
module mcu_strip #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int BITS_ADDR   = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BITS_IMAGEN-1:0]          i_Data,
    input  logic [(N+K-1)*BITS_DATA-1:0]    i_MemData,
    input  logic [N*BITS_DATA-1:0]          i_DataConv,
    input  logic [BITS_ADDR-1:0]            i_WAddr,
    input  logic [BITS_ADDR-1:0]            i_RAddr,
    input  logic                            i_chblk,
    input  logic                            i_sop,
    input  logic                            i_eop,
    output logic [K*N*BITS_IMAGEN-1:0]      o_DataConv,
    output logic [BITS_DATA-1:0]            o_Data,
    output logic [N+K-2:0]                  o_we,
    output logic [BITS_ADDR-1:0]            o_WAddr,
    output logic [BITS_ADDR-1:0]            o_RAddr,
    output logic [(N+K-1)*BITS_DATA-1:0]    o_MemData,
    output logic [1:0]                      o_state
);
    localparam int M  = N + K - 1;
    localparam int LW = (M > 1) ? $clog2(M) : 1;
    localparam int IW = $clog2(2 * M);
    localparam int CW = $clog2(M + 1);
    localparam int RW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_PROC  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // Every index sum stays below 2M, so a single conditional subtract replaces mod M.
    function automatic logic [LW-1:0] wrap(input logic [IW-1:0] s);
        return LW'((s >= IW'(M)) ? s - IW'(M) : s);
    endfunction

    state_t                     state_reg, state_next;
    logic [LW-1:0]              base_reg, base_next;
    logic [LW-1:0]              wp_reg, wp_next;
    logic [CW-1:0]              lcnt_reg, lcnt_next;
    logic [RW-1:0]              rp_reg, rp_next;
    logic                       chblk_d_reg;
    logic                       chblk_rise;

    logic [BITS_DATA-1:0]       mem_lane [M];
    logic [BITS_DATA-1:0]       conv_lane [N];
    logic [LW-1:0]              wb_bank [N];
    logic [K*N*BITS_IMAGEN-1:0] win_comb;
    logic [LW-1:0]              drain_idx;
    logic [LW-1:0]              base_rot;

    logic [M-1:0]               we_next;
    logic [BITS_DATA-1:0]       md_next [M];
    logic [M*BITS_DATA-1:0]     md_packed;
    logic [K*N*BITS_IMAGEN-1:0] conv_next;
    logic [BITS_DATA-1:0]       data_next;

    assign chblk_rise = i_chblk & ~chblk_d_reg;
    assign drain_idx  = wrap(IW'(base_reg) + IW'(rp_reg));
    assign base_rot   = wrap(IW'(base_reg) + IW'(N));

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_bank
            assign mem_lane[gi] = i_MemData[gi*BITS_DATA +: BITS_DATA];
            assign md_packed[gi*BITS_DATA +: BITS_DATA] = md_next[gi];
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_conv
            assign conv_lane[gi] = i_DataConv[gi*BITS_DATA +: BITS_DATA];
            assign wb_bank[gi]   = wrap(IW'(base_reg) + IW'(gi));
            // Convolver j sees K consecutive banks starting at its own rotated bank.
            for (genvar gr = 0; gr < K; gr++) begin : g_row
                logic [LW-1:0] idx;
                assign idx = wrap(IW'(base_reg) + IW'(gi + gr));
                assign win_comb[(gi*K+gr)*BITS_IMAGEN +: BITS_IMAGEN] = mem_lane[idx][BITS_IMAGEN-1:0];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        wp_next    = wp_reg;
        lcnt_next  = lcnt_reg;
        rp_next    = rp_reg;
        we_next    = '0;
        for (int b = 0; b < M; b++) begin
            md_next[b] = '0;
        end
        conv_next  = o_DataConv;
        data_next  = o_Data;

        unique case (state_reg)
            ST_LOAD: begin
                we_next = M'(1) << wp_reg;
                for (int b = 0; b < M; b++) begin
                    md_next[b] = BITS_DATA'(i_Data);
                end
                if (chblk_rise) begin
                    wp_next = wrap(IW'(wp_reg) + IW'(1));
                    if (lcnt_reg != CW'(M)) begin
                        lcnt_next = lcnt_reg + CW'(1);
                    end
                end
                if (i_sop && lcnt_reg == CW'(M)) begin
                    state_next = ST_PROC;
                end
            end
            ST_PROC: begin
                conv_next = win_comb;
                for (int j = 0; j < N; j++) begin
                    we_next[wb_bank[j]] = 1'b1;
                    md_next[wb_bank[j]] = conv_lane[j];
                end
                if (i_eop) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                data_next = mem_lane[drain_idx];
                if (chblk_rise) begin
                    // Last drained row: retire the N finished banks, keep the K-1 overlap rows.
                    if (rp_reg == RW'(N - 1)) begin
                        state_next = ST_LOAD;
                        base_next  = base_rot;
                        wp_next    = wrap(IW'(base_rot) + IW'(K - 1));
                        lcnt_next  = CW'(K - 1);
                        rp_next    = '0;
                    end else begin
                        rp_next = rp_reg + RW'(1);
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_LOAD;
            base_reg    <= '0;
            wp_reg      <= '0;
            lcnt_reg    <= '0;
            rp_reg      <= '0;
            chblk_d_reg <= 1'b0;
            o_DataConv  <= '0;
            o_Data      <= '0;
            o_we        <= '0;
            o_WAddr     <= '0;
            o_RAddr     <= '0;
            o_MemData   <= '0;
            o_state     <= 2'b00;
        end else begin
            state_reg   <= state_next;
            base_reg    <= base_next;
            wp_reg      <= wp_next;
            lcnt_reg    <= lcnt_next;
            rp_reg      <= rp_next;
            chblk_d_reg <= i_chblk;
            o_DataConv  <= conv_next;
            o_Data      <= data_next;
            o_we        <= we_next;
            o_WAddr     <= i_WAddr;
            o_RAddr     <= i_RAddr;
            o_MemData   <= md_packed;
            o_state     <= state_reg;
        end
    end
endmodule

// File: tb/tb_mcu_strip.sv
// Vector-table bench for mcu_strip (N=2, K=3, M=4): load, sop gating, windows,
// write-back, drain, bank rotation, priority and mid-run reset.
module tb_mcu_strip;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_Data = '0;
    logic [51:0] i_MemData = '0;
    logic [25:0] i_DataConv = '0;
    logic [9:0]  i_WAddr = '0;
    logic [9:0]  i_RAddr = '0;
    logic        i_chblk = 1'b0;
    logic        i_sop = 1'b0;
    logic        i_eop = 1'b0;
    logic [47:0] o_DataConv;
    logic [12:0] o_Data;
    logic [3:0]  o_we;
    logic [9:0]  o_WAddr;
    logic [9:0]  o_RAddr;
    logic [51:0] o_MemData;
    logic [1:0]  o_state;

    mcu_strip dut (
        .clk(clk), .rst(rst), .i_Data(i_Data), .i_MemData(i_MemData),
        .i_DataConv(i_DataConv), .i_WAddr(i_WAddr), .i_RAddr(i_RAddr),
        .i_chblk(i_chblk), .i_sop(i_sop), .i_eop(i_eop),
        .o_DataConv(o_DataConv), .o_Data(o_Data), .o_we(o_we),
        .o_WAddr(o_WAddr), .o_RAddr(o_RAddr), .o_MemData(o_MemData),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, chblk, sop, eop;
        logic [7:0]  data;
        logic [51:0] mem;
        logic [25:0] conv;
        logic [6:0]  mask;
        logic [3:0]  we;
        logic [1:0]  st;
        logic [51:0] md;
        logic [47:0] cv;
        logic [12:0] dt;
        logic [9:0]  ra, wa;
        int          idx;
    } vec_t;

    localparam logic [6:0] CK_WE = 7'h01, CK_ST = 7'h02, CK_MD = 7'h04, CK_CV = 7'h08;
    localparam logic [6:0] CK_DT = 7'h10, CK_RA = 7'h20, CK_WA = 7'h40, CK_ALL = 7'h7f;
    localparam logic [6:0] M_LD = CK_WE | CK_ST | CK_MD | CK_CV | CK_WA;
    localparam logic [6:0] M_PR = M_LD | CK_RA;
    localparam logic [6:0] M_DR = CK_WE | CK_ST | CK_MD | CK_CV | CK_DT | CK_RA;

    // Bank lanes are {lane3, lane2, lane1, lane0}; windows are {slice5 .. slice0}.
    localparam logic [51:0] MD1 = {13'd3, 13'd2, 13'd1, 13'd0};
    localparam logic [51:0] MD2 = {13'h0D33, 13'h0C22, 13'h0B11, 13'h1A00};
    localparam logic [25:0] CI  = {13'h0C1, 13'h0C0};
    localparam logic [51:0] PM0 = {13'd0, 13'd0, 13'h0C1, 13'h0C0};
    localparam logic [51:0] PM1 = {13'h0C1, 13'h0C0, 13'd0, 13'd0};
    localparam logic [47:0] W0  = {8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd0};
    localparam logic [47:0] W1  = {8'd1, 8'd0, 8'd3, 8'd0, 8'd3, 8'd2};

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_no = 0;

    function automatic logic [51:0] bc(input logic [7:0] d);
        return {4{{5'd0, d}}};
    endfunction

    function automatic vec_t mk(input logic r, input logic c, input logic s, input logic e,
                                input logic [7:0] d, input logic [51:0] m, input logic [25:0] cn,
                                input logic [6:0] msk, input logic [3:0] w, input logic [1:0] st,
                                input logic [51:0] md, input logic [47:0] cv, input logic [12:0] dt);
        vec_t v;
        v.rst = r; v.chblk = c; v.sop = s; v.eop = e; v.data = d; v.mem = m; v.conv = cn;
        v.mask = msk; v.we = w; v.st = st; v.md = md; v.cv = cv; v.dt = dt;
        v.ra = '0; v.wa = '0; v.idx = 0;
        return v;
    endfunction

    function automatic vec_t rs();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, '0, '0, CK_ALL, 4'b0, 2'b00, '0, '0, '0);
    endfunction

    function automatic vec_t ld(input logic c, input logic s, input logic [7:0] d,
                                input logic [3:0] w, input logic [47:0] cv);
        return mk(1'b0, c, s, 1'b0, d, '0, '0, M_LD, w, 2'b00, bc(d), cv, '0);
    endfunction

    function automatic vec_t pr(input logic s, input logic e, input logic [3:0] w,
                                input logic [51:0] md, input logic [47:0] cv);
        return mk(1'b0, 1'b0, s, e, 8'h00, MD1, CI, M_PR, w, 2'b01, md, cv, '0);
    endfunction

    function automatic vec_t dr(input logic c, input logic [12:0] dt);
        return mk(1'b0, c, 1'b0, 1'b0, 8'h00, MD2, CI, M_DR, 4'b0, 2'b10, '0, W0, dt);
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check(input vec_t e);
        if (e.mask[0]) cmp("o_we",       e.idx, 64'(o_we),       64'(e.we));
        if (e.mask[1]) cmp("o_state",    e.idx, 64'(o_state),    64'(e.st));
        if (e.mask[2]) cmp("o_MemData",  e.idx, 64'(o_MemData),  64'(e.md));
        if (e.mask[3]) cmp("o_DataConv", e.idx, 64'(o_DataConv), 64'(e.cv));
        if (e.mask[4]) cmp("o_Data",     e.idx, 64'(o_Data),     64'(e.dt));
        if (e.mask[5]) cmp("o_RAddr",    e.idx, 64'(o_RAddr),    64'(e.ra));
        if (e.mask[6]) cmp("o_WAddr",    e.idx, 64'(o_WAddr),    64'(e.wa));
        $display("vec %0d: rst=%0b chblk=%0b sop=%0b eop=%0b -> state=%b we=%b data=%h",
                 e.idx, e.rst, e.chblk, e.sop, e.eop, o_state, o_we, o_Data);
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst        = v.rst;
        i_chblk    = v.chblk;
        i_sop      = v.sop;
        i_eop      = v.eop;
        i_Data     = v.data;
        i_MemData  = v.mem;
        i_DataConv = v.conv;
        i_RAddr    = 10'(vec_no * 7 + 3);
        i_WAddr    = 10'(vec_no * 5 + 1);
        e     = v;
        e.idx = vec_no;
        e.ra  = v.rst ? 10'd0 : i_RAddr;
        e.wa  = v.rst ? 10'd0 : i_WAddr;
        sb.push_back(e);
        vec_no++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue, expected one entry", vec_no);
        end else begin
            check(sb.pop_front());
        end
    endtask

    initial begin
        // Reset, then a full 4-bank load with 2-cycle strobes; sop after 3 banks is ignored.
        tbl.push_back(rs());
        tbl.push_back(rs());
        tbl.push_back(ld(0, 0, 8'hAA, 4'b0001, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0001, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0010, '0));
        tbl.push_back(ld(0, 0, 8'hAA, 4'b0010, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0010, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0100, '0));
        tbl.push_back(ld(0, 0, 8'hAA, 4'b0100, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0100, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b1000, '0));
        tbl.push_back(ld(0, 1, 8'hAA, 4'b1000, '0));
        tbl.push_back(ld(0, 0, 8'hAA, 4'b1000, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b1000, '0));
        tbl.push_back(ld(1, 0, 8'hAA, 4'b0001, '0));
        tbl.push_back(ld(0, 1, 8'hAA, 4'b0001, '0));
        // PROC with base 0, then sop+eop together must go to DRAIN.
        tbl.push_back(pr(0, 0, 4'b0011, PM0, W0));
        tbl.push_back(pr(1, 1, 4'b0011, PM0, W0));
        // DRAIN two rows, rotate base to 2.
        tbl.push_back(dr(0, 13'h1A00));
        tbl.push_back(dr(1, 13'h1A00));
        tbl.push_back(dr(1, 13'h0B11));
        tbl.push_back(dr(0, 13'h0B11));
        tbl.push_back(dr(1, 13'h0B11));
        // Reload only 2 banks; sop coinciding with the last strobe uses the old count.
        tbl.push_back(ld(1, 0, 8'h55, 4'b0001, W0));
        tbl.push_back(ld(0, 0, 8'h55, 4'b0001, W0));
        tbl.push_back(ld(0, 1, 8'h55, 4'b0001, W0));
        tbl.push_back(ld(1, 0, 8'h55, 4'b0001, W0));
        tbl.push_back(ld(0, 0, 8'h55, 4'b0010, W0));
        tbl.push_back(ld(1, 1, 8'h55, 4'b0010, W0));
        tbl.push_back(ld(0, 1, 8'h55, 4'b0100, W0));
        tbl.push_back(pr(0, 0, 4'b1100, PM1, W1));
        // Reset mid-PROC: back to base 0, full 4-bank load needed.
        tbl.push_back(rs());
        tbl.push_back(ld(0, 0, 8'h33, 4'b0001, '0));
        tbl.push_back(ld(1, 0, 8'h33, 4'b0001, '0));
        tbl.push_back(ld(0, 0, 8'h33, 4'b0010, '0));
        tbl.push_back(ld(1, 0, 8'h33, 4'b0010, '0));
        tbl.push_back(ld(0, 0, 8'h33, 4'b0100, '0));
        tbl.push_back(ld(1, 0, 8'h33, 4'b0100, '0));
        tbl.push_back(ld(0, 1, 8'h33, 4'b1000, '0));
        tbl.push_back(ld(1, 0, 8'h33, 4'b1000, '0));
        tbl.push_back(ld(0, 1, 8'h33, 4'b0001, '0));
        tbl.push_back(pr(0, 0, 4'b0011, PM0, W0));

        foreach (tbl[i]) apply(tbl[i]);

        // Drain with a strobe held high for 4 cycles: only one row advance.
        apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, MD1, CI, CK_ST, 4'b0, 2'b01, '0, '0, '0));
        apply(dr(0, 13'h1A00));
        apply(dr(1, 13'h1A00));
        apply(dr(1, 13'h0B11));
        apply(dr(1, 13'h0B11));
        apply(dr(1, 13'h0B11));
        apply(dr(0, 13'h0B11));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: got %0d leftover entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
